// File: rtl/counter_cycle_arbiter.sv
// Cycle-stealing arbiter: shares the single-write-port erasable RAM between the Core
// and NUM_CNT counter-increment requesters. Optional macro CCA_DROP_CNT_EN adds drop_cnt.
module counter_cycle_arbiter #(
  parameter int                NUM_CNT  = 4,
  parameter int                ADDR_W   = 11,
  parameter int                DATA_W   = 15,
  parameter logic [ADDR_W-1:0] CNT_BASE = ADDR_W'('o0024)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               steal_en,
  input  logic [NUM_CNT-1:0] cnt_req,
  input  logic [ADDR_W-1:0]  core_rd_addr,
  input  logic [ADDR_W-1:0]  core_wr_addr,
  input  logic [DATA_W-1:0]  core_wr_data,
  input  logic               core_wr_en,
  input  logic [DATA_W-1:0]  ram_rd_data,
  output logic [ADDR_W-1:0]  ram_rd_addr,
  output logic [ADDR_W-1:0]  ram_wr_addr,
  output logic [DATA_W-1:0]  ram_wr_data,
  output logic               ram_wr_en,
  output logic               core_stall,
  output logic [NUM_CNT-1:0] cnt_ovf,
  output logic               busy,
`ifdef CCA_DROP_CNT_EN
  output logic [7:0]         drop_cnt,
`endif
  output logic [1:0]         state_dbg
);

  localparam int PTR_W = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1;

  localparam logic [DATA_W-1:0] MAX_POS  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] NEG_ZERO = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WAIT  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t             state;
  logic [NUM_CNT-1:0] pending;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   sel;
  logic [DATA_W-1:0]  old_word;

  logic [PTR_W-1:0]   arb_sel;
  logic               go;
  logic [NUM_CNT-1:0] clr_mask;
  logic [NUM_CNT-1:0] pending_nxt;
  logic [ADDR_W-1:0]  cnt_addr;
  logic [DATA_W-1:0]  new_word;

  // Ones'-complement increment: +max wraps to +0 (overflow), -0 steps to +1.
  function automatic logic [DATA_W-1:0] ones_inc(input logic [DATA_W-1:0] v);
    if (v == MAX_POS)       return '0;
    else if (v == NEG_ZERO) return ONE;
    else                    return v + ONE;
  endfunction

  // Round-robin search starting one past the last winner, wrapping at NUM_CNT.
  always_comb begin
    int idx;
    logic found;
    idx     = 0;
    found   = 1'b0;
    arb_sel = rr_ptr;
    for (int k = 1; k <= NUM_CNT; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_CNT;
      if (!found && pending[idx]) begin
        found   = 1'b1;
        arb_sel = PTR_W'(idx);
      end
    end
  end

  // Request interface: cnt_req[i] is a fire-and-forget pulse (no ready); it is
  // accepted into pending[i] unless pending[i] is already set, in which case it merges.
  assign go          = (state == S_IDLE) & steal_en & (|pending) & ~core_wr_en;
  assign clr_mask    = go ? (NUM_CNT'(1) << arb_sel) : '0;
  assign pending_nxt = (pending & ~clr_mask) | cnt_req;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pending    <= '0;
      rr_ptr     <= PTR_W'(NUM_CNT - 1);
      sel        <= '0;
      old_word   <= '0;
      cnt_ovf    <= '0;
      core_stall <= 1'b0;
      busy       <= 1'b0;
    end else begin
      pending <= pending_nxt;
      cnt_ovf <= '0;
      case (state)
        S_IDLE: begin
          if (go) begin
            state      <= S_READ;
            sel        <= arb_sel;
            rr_ptr     <= arb_sel;
            core_stall <= 1'b1;
            busy       <= 1'b1;
          end
        end
        S_READ: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          // RAM q now holds the counter word addressed during READ.
          state    <= S_WRITE;
          old_word <= ram_rd_data;
          if (ram_rd_data == MAX_POS) cnt_ovf <= NUM_CNT'(1) << sel;
        end
        S_WRITE: begin
          state      <= S_IDLE;
          core_stall <= 1'b0;
          busy       <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign cnt_addr = CNT_BASE + {{(ADDR_W-PTR_W){1'b0}}, sel};
  assign new_word = ones_inc(old_word);

  assign ram_rd_addr = (state == S_READ)  ? cnt_addr : core_rd_addr;
  assign ram_wr_addr = (state == S_WRITE) ? cnt_addr : core_wr_addr;
  assign ram_wr_data = (state == S_WRITE) ? new_word : core_wr_data;
  // Core writes are suppressed for the whole steal, not just the write slot.
  assign ram_wr_en   = (state == S_WRITE) | ((state == S_IDLE) & core_wr_en);
  assign state_dbg   = state;

`ifdef CCA_DROP_CNT_EN
  logic drop_hit;

  assign drop_hit = |(cnt_req & pending & ~clr_mask);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (drop_hit && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`endif

endmodule
